alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and result width in bits; legal values are even and at least 8.
REQ-002 SHALL have parameter CNT_WIDTH, default $clog2(DATA_WIDTH)+1, iteration counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port SrcA  input  DATA_WIDTH  operand A: multiplicand or dividend.
REQ-008 SHALL have port SrcB  input  DATA_WIDTH  operand B: multiplier or divisor.
REQ-009 SHALL have port Operation  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-010 SHALL have port flush  input  1  abort any in-flight operation.
REQ-011 SHALL have port out_valid  output  1  ALUResult valid.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result.
REQ-013 SHALL have port ALUResult  output  DATA_WIDTH  result, registered.
REQ-014 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, CALC and DONE.
REQ-016 in_ready SHALL be high only in IDLE; a request is accepted on a rising edge with in_valid && in_ready.
REQ-017 On acceptance, SHALL latch operands, Operation and signedness, and load the counter with DATA_WIDTH.
REQ-018 The normal path SHALL go IDLE->CALC, running one shift-add (multiply) or restoring-subtract (divide) step per cycle on unsigned magnitudes, decrementing the counter each step.
REQ-019 The transition CALC->DONE SHALL occur on the edge where the counter reaches 0; out_valid rises DATA_WIDTH+1 edges after the accept edge.
REQ-020 Multiply SHALL form a 2*DATA_WIDTH product: MUL returns the low half; MULH treats both operands as signed and returns the high half; MULHSU treats A signed, B unsigned, high half; MULHU treats both unsigned, high half.
REQ-021 Signed operations SHALL convert negative operands to magnitude and negate the final result when the sign rule requires it: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
REQ-022 DIV and DIVU with SrcB==0 SHALL take a fast path IDLE->DONE, quotient all-ones; REM and REMU with SrcB==0 SHALL return SrcA.
REQ-023 DIV with SrcA = most-negative value and SrcB = -1 SHALL take the fast path: quotient SrcA, REM result 0.
REQ-024 Fast-path results SHALL have out_valid high 1 edge after the accept edge.
REQ-025 In DONE, out_valid and ALUResult SHALL hold stable until out_valid && out_ready; on that edge the FSM returns to IDLE.
REQ-026 in_ready SHALL be low in DONE, so back-to-back requests are not overlapped; the next accept happens at the earliest on the edge after the handshake.
REQ-027 in_valid while busy SHALL be ignored, with no state change.
REQ-028 flush SHALL have priority over all handshakes: the FSM goes to IDLE on the next edge, out_valid goes low and the result is discarded; flush in IDLE has no effect.
REQ-029 Operands SHALL be sampled only at accept; input changes during CALC SHALL NOT affect the result.

Reset
REQ-030 When reset is high at a rising edge, the FSM SHALL enter IDLE and clear the counter, with out_valid=0, ALUResult=0, busy=0 and in_ready=1 after that edge.
REQ-031 Reset SHALL take priority over flush and in_valid, including mid-CALC and in DONE; the in-flight result is lost.

Verification
REQ-032 MUL, A=7, B=0xFFFFFFFD, out_ready=1 -> out_valid after exactly 33 edges, ALUResult=0xFFFFFFEB, then in_ready=1 the next cycle.
REQ-033 A=B=0xFFFFFFFF: MULHU -> 0xFFFFFFFE; MULH -> 0x00000000; MULHSU -> 0xFFFFFFFF.
REQ-034 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 5/0 -> 0xFFFFFFFF with latency 1; REMU 5/0 -> 5.
REQ-035 DIV 0x80000000/0xFFFFFFFF -> 0x80000000 with latency 1; REM -> 0.
REQ-036 Hold out_ready=0 for 10 cycles in DONE -> out_valid and ALUResult stable, in_ready=0, and a second in_valid is ignored; on out_ready=1, exactly one handshake occurs.
REQ-037 Assert reset at CALC cycle 10, and separately flush at CALC cycle 10 -> next cycle IDLE, out_valid=0 and busy=0; a fresh MULHU 3*5 then returns 0x00000000 with correct latency.

Source files
------------

// File: rtl/alu_muldiv_if.sv
// Request/response bundle for the iterative multiply/divide unit.
interface alu_muldiv_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] SrcA;
  logic [DATA_WIDTH-1:0] SrcB;
  logic [2:0]            Operation;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] ALUResult;
  logic                  busy;

  modport master (
    output in_valid, SrcA, SrcB, Operation, flush, out_ready,
    input  in_ready, out_valid, ALUResult, busy
  );

  modport slave (
    input  in_valid, SrcA, SrcB, Operation, flush, out_ready,
    output in_ready, out_valid, ALUResult, busy
  );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-subtract step per cycle.
module alu_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input logic         clk,
  input logic         reset,
  alu_muldiv_if.slave bus
);
  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_t;

  state_t               state_q, state_d;
  op_t                  op_in, op_q;
  logic                 is_div_q;
  logic                 neg_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [W-1:0]         hi_q, lo_q, d_q;
  logic [W-1:0]         result_q;

  logic                 accept;
  logic                 sign_a, sign_b, neg_a, neg_b, neg_in;
  logic [W-1:0]         mag_a, mag_b;
  logic                 is_div_in, div_zero, div_ovf, fast;
  logic [W-1:0]         fast_result;

  logic [W:0]           mul_sum, rem_shift, rem_diff;
  logic [W-1:0]         hi_nx, lo_nx;
  logic [2*W-1:0]       prod_fix;
  logic [W-1:0]         quo_fix, rem_fix, final_result;

  assign op_in         = op_t'(bus.Operation);
  assign accept        = bus.in_valid && (state_q == IDLE) && !bus.flush;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.ALUResult = result_q;

  // Operand signedness, magnitudes, result sign and fast-path detection at accept.
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (op_in)
      OP_MULH, OP_DIV, OP_REM: begin
        sign_a = 1'b1;
        sign_b = 1'b1;
      end
      OP_MULHSU: sign_a = 1'b1;
      default: ;
    endcase
    neg_a     = sign_a & bus.SrcA[W-1];
    neg_b     = sign_b & bus.SrcB[W-1];
    mag_a     = neg_a ? -bus.SrcA : bus.SrcA;
    mag_b     = neg_b ? -bus.SrcB : bus.SrcB;
    neg_in    = (op_in == OP_REM) ? neg_a : (neg_a ^ neg_b);
    is_div_in = bus.Operation[2];
    div_zero  = (bus.SrcB == '0);
    div_ovf   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                (bus.SrcA == MIN_VAL) && (bus.SrcB == '1);
    fast      = is_div_in && (div_zero || div_ovf);
    fast_result = '0;
    case (op_in)
      OP_DIV, OP_DIVU: fast_result = div_zero ? '1 : bus.SrcA;
      OP_REM, OP_REMU: fast_result = div_zero ? bus.SrcA : '0;
      default: ;
    endcase
  end

  // One iteration step; the final result is formed from the post-step values so that
  // the last step and the move to DONE share an edge.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, d_q} : '0);
    rem_shift = {hi_q, lo_q[W-1]};
    rem_diff  = rem_shift - {1'b0, d_q};
    if (is_div_q) begin
      hi_nx = rem_diff[W] ? rem_shift[W-1:0] : rem_diff[W-1:0];
      lo_nx = {lo_q[W-2:0], ~rem_diff[W]};
    end else begin
      hi_nx = mul_sum[W:1];
      lo_nx = {mul_sum[0], lo_q[W-1:1]};
    end
    prod_fix = neg_q ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
    quo_fix  = neg_q ? -lo_nx : lo_nx;
    rem_fix  = neg_q ? -hi_nx : hi_nx;
    case (op_q)
      OP_MUL:                       final_result = prod_fix[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod_fix[2*W-1:W];
      OP_DIV, OP_DIVU:              final_result = quo_fix;
      default:                      final_result = rem_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = fast ? DONE : CALC;
      CALC: if (cnt_q == CNT_WIDTH'(1)) state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  // Datapath: operand capture, iteration and result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_MUL;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      d_q      <= '0;
      result_q <= '0;
    end else if (!bus.flush) begin
      case (state_q)
        IDLE: if (accept) begin
          op_q     <= op_in;
          is_div_q <= is_div_in;
          neg_q    <= neg_in;
          cnt_q    <= CNT_WIDTH'(W);
          hi_q     <= '0;
          lo_q     <= is_div_in ? mag_a : mag_b;
          d_q      <= is_div_in ? mag_b : mag_a;
          if (fast) result_q <= fast_result;
        end
        CALC: begin
          hi_q  <= hi_nx;
          lo_q  <= lo_nx;
          cnt_q <= cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) result_q <= final_result;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed checks for alu_muldiv with DATA_WIDTH=32.
module tb_alu_muldiv;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  alu_muldiv_if #(.DATA_WIDTH(32)) bus ();

  alu_muldiv #(.DATA_WIDTH(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Issue one request, scramble the inputs after accept, wait for out_valid (bounded).
  // Latency counts edges with the accept edge as edge 1. Consumes the result if out_ready.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    bus.Operation = op;
    bus.SrcA      = a;
    bus.SrcB      = b;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.SrcA      = ~a;
    bus.SrcB      = a ^ b ^ 32'h5A5A_A5A5;
    bus.Operation = ~op;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.ALUResult;
    if (bus.out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.ALUResult !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=00000000", bus.ALUResult); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_mul();
    logic [31:0] r;
    int lat;
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, r, lat);
    checks++; if (r !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mul_7xm3 got=%h exp=ffffffeb", r); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL mul_latency got=%0d exp=33", lat); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL mul_in_ready_after got=%b exp=1", bus.in_ready); end
    run_op(3'b000, 32'h1234_5678, 32'h10, r, lat);
    checks++; if (r !== 32'h2345_6780) begin failures++; $display("FAIL mul_shift got=%h exp=23456780", r); end
    run_op(3'b011, 32'h8000_0000, 32'd4, r, lat);
    checks++; if (r !== 32'h0000_0002) begin failures++; $display("FAIL mulhu_pow2 got=%h exp=00000002", r); end
  endtask

  task automatic test_mulh();
    logic [31:0] r;
    int lat;
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
    checks++; if (r !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulhu_ones got=%h exp=fffffffe", r); end
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
    checks++; if (r !== 32'h0000_0000) begin failures++; $display("FAIL mulh_ones got=%h exp=00000000", r); end
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mulhsu_ones got=%h exp=ffffffff", r); end
  endtask

  task automatic test_div();
    logic [31:0] r;
    int lat;
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, r, lat);
    checks++; if (r !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_m7_2 got=%h exp=fffffffd", r); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL div_latency got=%0d exp=33", lat); end
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, r, lat);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rem_m7_2 got=%h exp=ffffffff", r); end
    run_op(3'b101, 32'd100, 32'd7, r, lat);
    checks++; if (r !== 32'd14) begin failures++; $display("FAIL divu_100_7 got=%h exp=0000000e", r); end
    run_op(3'b111, 32'd100, 32'd7, r, lat);
    checks++; if (r !== 32'd2) begin failures++; $display("FAIL remu_100_7 got=%h exp=00000002", r); end
    run_op(3'b100, 32'd7, 32'hFFFF_FFFE, r, lat);
    checks++; if (r !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_7_m2 got=%h exp=fffffffd", r); end
    run_op(3'b110, 32'd7, 32'hFFFF_FFFE, r, lat);
    checks++; if (r !== 32'd1) begin failures++; $display("FAIL rem_7_m2 got=%h exp=00000001", r); end
  endtask

  task automatic test_div_zero();
    logic [31:0] r;
    int lat;
    run_op(3'b101, 32'd5, 32'd0, r, lat);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divu_by0 got=%h exp=ffffffff", r); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL divu_by0_latency got=%0d exp=1", lat); end
    run_op(3'b111, 32'd5, 32'd0, r, lat);
    checks++; if (r !== 32'd5) begin failures++; $display("FAIL remu_by0 got=%h exp=00000005", r); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL remu_by0_latency got=%0d exp=1", lat); end
    run_op(3'b100, 32'hFFFF_FFF9, 32'd0, r, lat);
    checks++; if (r !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_by0 got=%h exp=ffffffff", r); end
    run_op(3'b110, 32'hFFFF_FFF9, 32'd0, r, lat);
    checks++; if (r !== 32'hFFFF_FFF9) begin failures++; $display("FAIL rem_by0 got=%h exp=fffffff9", r); end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    int lat;
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    checks++; if (r !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf got=%h exp=80000000", r); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL div_ovf_latency got=%0d exp=1", lat); end
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL rem_ovf got=%h exp=00000000", r); end
    checks++; if (lat !== 1) begin failures++; $display("FAIL rem_ovf_latency got=%0d exp=1", lat); end
  endtask

  task automatic test_hold();
    logic [31:0] r;
    int lat;
    bus.out_ready = 1'b0;
    run_op(3'b000, 32'd3, 32'd4, r, lat);
    checks++; if (r !== 32'd12) begin failures++; $display("FAIL hold_result got=%h exp=0000000c", r); end
    bus.Operation = 3'b000;
    bus.SrcA      = 32'd9;
    bus.SrcB      = 32'd9;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL hold_out_valid cyc=%0d got=%b exp=1", i, bus.out_valid); end
      checks++; if (bus.ALUResult !== 32'd12) begin failures++; $display("FAIL hold_stable cyc=%0d got=%h exp=0000000c", i, bus.ALUResult); end
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL hold_handshake_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL hold_handshake_busy got=%b exp=0", bus.busy); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL hold_single_handshake got=%b exp=0", bus.out_valid); end
  endtask

  // Abort mid-CALC with reset (use_reset=1) or flush, then run a fresh MULHU 3*5.
  task automatic test_abort(input bit use_reset);
    logic [31:0] r;
    int lat;
    bus.Operation = 3'b000;
    bus.SrcA      = 32'd11;
    bus.SrcB      = 32'd13;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    if (use_reset) reset = 1'b1;
    else bus.flush = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.flush = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy rst=%0d got=%b exp=0", use_reset, bus.busy); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid rst=%0d got=%b exp=0", use_reset, bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL abort_in_ready rst=%0d got=%b exp=1", use_reset, bus.in_ready); end
    if (use_reset) begin
      checks++; if (bus.ALUResult !== 32'h0) begin failures++; $display("FAIL abort_reset_result got=%h exp=00000000", bus.ALUResult); end
    end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL abort_no_late_valid rst=%0d got=%b exp=0", use_reset, bus.out_valid); end
    run_op(3'b011, 32'd3, 32'd5, r, lat);
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL abort_fresh_mulhu rst=%0d got=%h exp=00000000", use_reset, r); end
    checks++; if (lat !== 33) begin failures++; $display("FAIL abort_fresh_latency rst=%0d got=%0d exp=33", use_reset, lat); end
  endtask

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.SrcA      = '0;
    bus.SrcB      = '0;
    bus.Operation = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_div_zero();
    test_overflow();
    test_hold();
    test_abort(1'b1);
    test_abort(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
